// File: rtl/onehot_reg_bank8.sv
// Eight-entry register bank written through a one-hot select from the
// upstream write-address decoder. Two registered read ports with
// write-through bypass. Multi-hot selects are blocked, flagged and counted.
module onehot_reg_bank8 #(
   parameter int WIDTH    = 16,
   parameter bit ZERO_REG = 1'b0,
   parameter int ERRW     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [2:0]       rd_addr_a,
   input  logic [2:0]       rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             sel_err,
   output logic [ERRW-1:0]  err_count,
   input  logic             clr_err
);

   localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

   logic [WIDTH-1:0] regs [0:7];

   logic [3:0]       selCount;
   logic [2:0]       wrIdx;
   logic             selLegal;
   logic             selMulti;
   logic             wrEnable;
   logic [WIDTH-1:0] readNextA;
   logic [WIDTH-1:0] readNextB;

   // Classify the select by popcount and encode the selected entry index;
   // the index is only meaningful when exactly one bit is set.
   always_comb begin
      selCount = 4'd0;
      wrIdx    = 3'd0;
      for (int i = 0; i < 8; i++) begin
         selCount = selCount + {3'b000, wr_sel[i]};
         if (wr_sel[i]) begin
            wrIdx = 3'(i);
         end
      end
      selLegal = (selCount == 4'd1);
      selMulti = (selCount >= 4'd2);
      wrEnable = selLegal && !(ZERO_REG && (wrIdx == 3'd0));
   end

   // Next read values: hardwired zero entry first, then same-cycle write
   // bypass so a read never sees the value being overwritten, else storage.
   always_comb begin
      readNextA = regs[rd_addr_a];
      if (ZERO_REG && (rd_addr_a == 3'd0)) begin
         readNextA = '0;
      end else if (wrEnable && (wrIdx == rd_addr_a)) begin
         readNextA = wr_data;
      end

      readNextB = regs[rd_addr_b];
      if (ZERO_REG && (rd_addr_b == 3'd0)) begin
         readNextB = '0;
      end else if (wrEnable && (wrIdx == rd_addr_b)) begin
         readNextB = wr_data;
      end
   end

   // Register storage: cleared on reset, otherwise one legal write per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
      end else if (wrEnable) begin
         regs[wrIdx] <= wr_data;
      end
   end

   // Registered read ports.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else begin
         rd_data_a <= readNextA;
         rd_data_b <= readNextB;
      end
   end

   // Sticky error flag and saturating counter; a clear that coincides with
   // a new multi-hot select still records that new error.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_err   <= 1'b0;
         err_count <= '0;
      end else if (clr_err) begin
         sel_err   <= selMulti;
         err_count <= selMulti ? ERRW'(1) : '0;
      end else if (selMulti) begin
         sel_err <= 1'b1;
         if (err_count != ERR_MAX) begin
            err_count <= err_count + ERRW'(1);
         end
      end
   end

endmodule

// File: doc/onehot_reg_bank8.md
Name: onehot_reg_bank8

Overview:
- Eight-entry register bank consuming the one-hot write-select vector produced by the 3-to-8 write-address decoder (enable already folded into the select).
- Two registered read ports with write-through bypass.
- Illegal (multi-hot) selects are detected, blocked, counted and flagged.
- Sits directly downstream of the write-address decoder in the register-file datapath.

Parameters:
- WIDTH, 16, data width of each register and of the read/write data buses.
- ZERO_REG, 0, 1: entry 0 is hardwired to zero and writes to it are discarded; 0: entry 0 is an ordinary register.
- ERRW, 4, width of the saturating illegal-select counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- wr_sel  input  8  one-hot write select from the decoder; bit k selects entry k; all-zero means no write.
- wr_data  input  WIDTH  write data, sampled with wr_sel.
- rd_addr_a  input  3  read port A address.
- rd_addr_b  input  3  read port B address.
- rd_data_a  output  WIDTH  registered read data, port A.
- rd_data_b  output  WIDTH  registered read data, port B.
- sel_err  output  1  sticky flag: a multi-hot wr_sel has been seen.
- err_count  output  ERRW  saturating count of multi-hot wr_sel cycles.
- clr_err  input  1  clears sel_err and err_count.

Behaviour:
- Clock and reset (fixed): one clock, clk. Reset is synchronous and active-high. When reset is high at a rising edge:
  - all eight entries are set to 0;
  - rd_data_a, rd_data_b, sel_err and err_count are set to 0.
- Reset overrides every other input in that cycle; no write occurs.
- Reset asserted mid-operation simply wins at the next edge; nothing from the reset cycle survives.
- Select classification is combinational on wr_sel:
  - NONE: popcount 0.
  - LEGAL: popcount 1.
  - MULTI: popcount 2 or more.
- Write:
  - On a rising edge with LEGAL, the selected entry k takes wr_data.
  - The write is discarded if k == 0 and ZERO_REG == 1.
  - NONE and MULTI write nothing; all entries are unchanged.
- Error tracking:
  - On a MULTI edge, sel_err is set to 1 and err_count increments, saturating at 2^ERRW-1.
  - clr_err high at an edge forces sel_err = 0 and err_count = 0.
  - If clr_err and MULTI occur in the same cycle, the result is sel_err = 1 and err_count = 1; the new error is not lost.
- Read:
  - rd_data_x registers the contents of entry rd_addr_x at each rising edge, so data appears 1 cycle after the address.
  - Bypass: if the same edge performs a LEGAL, non-discarded write to entry rd_addr_x, rd_data_x takes wr_data (write-through). The read never returns the stale value.
  - Reads of entry 0 with ZERO_REG == 1 always return 0, including during an attempted write to entry 0.
  - Both ports may read the same entry in the same cycle; both return identical data.
- No back-pressure and no stalls: one write and two reads per cycle, every cycle.
- All arithmetic is unsigned.
- err_count wrap-around is forbidden: it saturates.

Test Plan:
- Reset, then read all eight addresses on both ports -> every rd_data = 0, sel_err = 0, err_count = 0.
- Write 0x1111 with wr_sel=8'b0000_0100, then read rd_addr_a=2 next cycle -> rd_data_a = 0x1111 one cycle after the address; all other entries remain 0.
- Same-cycle wr_sel=8'b1000_0000, wr_data=0xBEEF, rd_addr_a=rd_addr_b=7 -> both rd_data = 0xBEEF on the next edge (bypass). Repeat with ZERO_REG=1 and wr_sel=8'b0000_0001 -> rd_data stays 0.
- wr_sel=8'b0011_0000, wr_data=0xFFFF -> entries 4 and 5 unchanged, sel_err = 1, err_count = 1. Apply 20 further multi-hot cycles -> err_count saturates at 15.
- clr_err together with wr_sel=8'b1100_0000 -> sel_err = 1, err_count = 1. clr_err alone the next cycle -> both 0.
- Load all entries with distinct values, then assert reset together with a LEGAL write -> all entries and outputs 0; the write is discarded.
